// File: rtl/vga_pkg.sv
// Shared defaults and helpers for the VGA display path.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned CNT_W_DEF    = 10;

   typedef struct packed {
      logic left;
      logic right;
      logic up;
      logic down;
   } cursor_move_t;

   typedef enum logic [1:0] {
      WRAP_HOLD = 2'd0,
      WRAP_INC  = 2'd1,
      WRAP_DEC  = 2'd2
   } wrap_dir_t;

   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   // Opposing requests cancel each other out.
   function automatic wrap_dir_t wrap_dir(input logic inc, input logic dec);
      if (inc && !dec) return WRAP_INC;
      if (dec && !inc) return WRAP_DEC;
      return WRAP_HOLD;
   endfunction

endpackage

// File: rtl/vga_tile_tracker_axis.sv
// One axis of the tile grid: offset inside the tile plus tile index, restart/wrap/saturate.
module tile_axis_counter
   import vga_pkg::*;
#(
   parameter  int unsigned TILE  = 320,
   parameter  int unsigned N     = 2,
   localparam int unsigned OFF_W = clog2_min1(TILE),
   localparam int unsigned IDX_W = clog2_min1(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_i,
   input  logic             restart_i,
   output logic [OFF_W-1:0] off_o,
   output logic [IDX_W-1:0] idx_o
);

   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(TILE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   logic [OFF_W-1:0] off_q, off_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   // Index sticks at the last tile so overscan past the active area stays in range.
   always_comb begin
      off_d = off_q;
      idx_d = idx_q;
      if (step_i) begin
         if (restart_i) begin
            off_d = '0;
            idx_d = '0;
         end else if (off_q == OFF_LAST) begin
            off_d = '0;
            if (idx_q != IDX_LAST) begin
               idx_d = idx_q + 1'b1;
            end
         end else begin
            off_d = off_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         off_q <= '0;
         idx_q <= '0;
      end else begin
         off_q <= off_d;
         idx_q <= idx_d;
      end
   end

   assign off_o = off_q;
   assign idx_o = idx_q;

endmodule

// File: rtl/vga_tile_tracker.sv
// Divider-free tile index/offset tracker driven by VGA counters, plus a wrapping cursor tile.
module vga_tile_tracker
   import vga_pkg::*;
#(
   parameter  int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter  int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter  int unsigned COLS     = 2,
   parameter  int unsigned ROWS     = 2,
   parameter  int unsigned CNT_W    = CNT_W_DEF,
   localparam int unsigned TILE_W   = H_ACTIVE / COLS,
   localparam int unsigned TILE_H   = V_ACTIVE / ROWS,
   localparam int unsigned IDX_W    = clog2_min1(COLS * ROWS),
   localparam int unsigned X_W      = clog2_min1(TILE_W),
   localparam int unsigned Y_W      = clog2_min1(TILE_H)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   input  logic [CNT_W-1:0] hcnt,
   input  logic [CNT_W-1:0] vcnt,
   input  logic             mv_left,
   input  logic             mv_right,
   input  logic             mv_up,
   input  logic             mv_down,
   output logic             in_active,
   output logic [IDX_W-1:0] tile_idx,
   output logic [X_W-1:0]   tile_x,
   output logic [Y_W-1:0]   tile_y,
   output logic [IDX_W-1:0] cursor_idx,
   output logic             cursor_hit
);

   localparam int unsigned      COL_W    = clog2_min1(COLS);
   localparam int unsigned      ROW_W    = clog2_min1(ROWS);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   logic             line_start;
   logic             frame_start;
   logic             active_now;
   logic [X_W-1:0]   xoff;
   logic [COL_W-1:0] col;
   logic [Y_W-1:0]   yoff;
   logic [ROW_W-1:0] row;
   logic [IDX_W-1:0] tile_idx_raw;

   logic             in_active_q, in_active_d;
   cursor_move_t     mv;
   logic [COL_W-1:0] cur_col_q, cur_col_d;
   logic [ROW_W-1:0] cur_row_q, cur_row_d;
   logic [IDX_W-1:0] cursor_idx_q, cursor_idx_d;

   assign line_start  = (hcnt == '0);
   assign frame_start = (vcnt == '0);
   assign active_now  = (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);

   tile_axis_counter #(
      .TILE (TILE_W),
      .N    (COLS)
   ) u_h_axis (
      .clk       (clk),
      .rst       (reset),
      .step_i    (pix_en),
      .restart_i (line_start),
      .off_o     (xoff),
      .idx_o     (col)
   );

   // The vertical axis only advances on the first pixel tick of each line.
   tile_axis_counter #(
      .TILE (TILE_H),
      .N    (ROWS)
   ) u_v_axis (
      .clk       (clk),
      .rst       (reset),
      .step_i    (pix_en & line_start),
      .restart_i (frame_start),
      .off_o     (yoff),
      .idx_o     (row)
   );

   assign in_active_d = pix_en ? active_now : in_active_q;
   assign mv          = {mv_left, mv_right, mv_up, mv_down};

   always_comb begin
      cur_col_d = cur_col_q;
      cur_row_d = cur_row_q;
      case (wrap_dir(mv.right, mv.left))
         WRAP_INC: cur_col_d = (cur_col_q == COL_LAST) ? '0 : cur_col_q + 1'b1;
         WRAP_DEC: cur_col_d = (cur_col_q == '0) ? COL_LAST : cur_col_q - 1'b1;
         default:  cur_col_d = cur_col_q;
      endcase
      case (wrap_dir(mv.down, mv.up))
         WRAP_INC: cur_row_d = (cur_row_q == ROW_LAST) ? '0 : cur_row_q + 1'b1;
         WRAP_DEC: cur_row_d = (cur_row_q == '0) ? ROW_LAST : cur_row_q - 1'b1;
         default:  cur_row_d = cur_row_q;
      endcase
      cursor_idx_d = IDX_W'(32'(cur_row_d) * COLS + 32'(cur_col_d));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_active_q  <= 1'b0;
         cur_col_q    <= '0;
         cur_row_q    <= '0;
         cursor_idx_q <= '0;
      end else begin
         in_active_q  <= in_active_d;
         cur_col_q    <= cur_col_d;
         cur_row_q    <= cur_row_d;
         cursor_idx_q <= cursor_idx_d;
      end
   end

   // Trackers keep running through blanking; only the visible outputs are gated.
   assign tile_idx_raw = IDX_W'(32'(row) * COLS + 32'(col));
   assign in_active    = in_active_q;
   assign tile_idx     = in_active_q ? tile_idx_raw : '0;
   assign tile_x       = in_active_q ? xoff : '0;
   assign tile_y       = in_active_q ? yoff : '0;
   assign cursor_idx   = cursor_idx_q;
   assign cursor_hit   = in_active_q && (tile_idx_raw == cursor_idx_q);

endmodule

// File: tb/tb_vga_tile_tracker.sv
// Scoreboard bench for vga_tile_tracker: a 2x2 and a 4x3 instance share one randomized stimulus stream.
module tb_vga_tile_tracker;

   localparam int HA = 640;
   localparam int VA = 480;
   localparam int HT = 800;
   localparam int VT = 525;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       pix_en   = 1'b0;
   logic [9:0] hcnt     = '0;
   logic [9:0] vcnt     = '0;
   logic       mv_left  = 1'b0;
   logic       mv_right = 1'b0;
   logic       mv_up    = 1'b0;
   logic       mv_down  = 1'b0;
   logic       drv_vld  = 1'b0;

   logic       a_in_active, a_cursor_hit;
   logic [1:0] a_tile_idx, a_cursor_idx;
   logic [8:0] a_tile_x;
   logic [7:0] a_tile_y;
   logic       b_in_active, b_cursor_hit;
   logic [3:0] b_tile_idx, b_cursor_idx;
   logic [7:0] b_tile_x;
   logic [7:0] b_tile_y;

   always #5 clk = ~clk;

   vga_tile_tracker #(.COLS(2), .ROWS(2)) u_dut_a (
      .clk(clk), .reset(reset), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt),
      .mv_left(mv_left), .mv_right(mv_right), .mv_up(mv_up), .mv_down(mv_down),
      .in_active(a_in_active), .tile_idx(a_tile_idx), .tile_x(a_tile_x), .tile_y(a_tile_y),
      .cursor_idx(a_cursor_idx), .cursor_hit(a_cursor_hit)
   );

   vga_tile_tracker #(.COLS(4), .ROWS(3)) u_dut_b (
      .clk(clk), .reset(reset), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt),
      .mv_left(mv_left), .mv_right(mv_right), .mv_up(mv_up), .mv_down(mv_down),
      .in_active(b_in_active), .tile_idx(b_tile_idx), .tile_x(b_tile_x), .tile_y(b_tile_y),
      .cursor_idx(b_cursor_idx), .cursor_hit(b_cursor_hit)
   );

   typedef struct {
      int act;
      int idx;
      int x;
      int y;
      int cidx;
      int hit;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   nvec = 0;
   int   nerr = 0;

   // Reference state: ticks since the last line/frame restart, and cursor column/row.
   int ncols[2] = '{2, 4};
   int nrows[2] = '{2, 3};
   int hpos[2];
   int vpos[2];
   int mact[2];
   int ccol[2];
   int crow[2];

   function automatic exp_t predict(input int k);
      exp_t e;
      int tw, th, c, r;
      tw = HA / ncols[k];
      th = VA / nrows[k];
      c  = hpos[k] / tw;
      r  = vpos[k] / th;
      if (c > ncols[k] - 1) c = ncols[k] - 1;
      if (r > nrows[k] - 1) r = nrows[k] - 1;
      e.act  = mact[k];
      e.idx  = mact[k] ? r * ncols[k] + c : 0;
      e.x    = mact[k] ? hpos[k] % tw : 0;
      e.y    = mact[k] ? vpos[k] % th : 0;
      e.cidx = crow[k] * ncols[k] + ccol[k];
      e.hit  = (mact[k] != 0 && e.idx == e.cidx) ? 1 : 0;
      return e;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         hpos[k] = 0; vpos[k] = 0; mact[k] = 0; ccol[k] = 0; crow[k] = 0;
      end
   endtask

   task automatic model_step(input bit pe, input int h, input int v, input logic [3:0] mv);
      for (int k = 0; k < 2; k++) begin
         if (pe) begin
            mact[k] = (h < HA && v < VA) ? 1 : 0;
            if (h == 0) begin
               hpos[k] = 0;
               if (v == 0) vpos[k] = 0;
               else        vpos[k]++;
            end else begin
               hpos[k]++;
            end
         end
         if (mv[2] && !mv[3]) ccol[k] = (ccol[k] + 1) % ncols[k];
         if (mv[3] && !mv[2]) ccol[k] = (ccol[k] + ncols[k] - 1) % ncols[k];
         if (mv[0] && !mv[1]) crow[k] = (crow[k] + 1) % nrows[k];
         if (mv[1] && !mv[0]) crow[k] = (crow[k] + nrows[k] - 1) % nrows[k];
         if (k == 0) q0.push_back(predict(0));
         else        q1.push_back(predict(1));
      end
   endtask

   task automatic drive(input bit pe, input int h, input int v, input logic [3:0] mv);
      @(negedge clk);
      pix_en   = pe;
      hcnt     = 10'(h);
      vcnt     = 10'(v);
      mv_left  = mv[3];
      mv_right = mv[2];
      mv_up    = mv[1];
      mv_down  = mv[0];
      drv_vld  = 1'b1;
      model_step(pe, h, v, mv);
   endtask

   task automatic idle();
      @(negedge clk);
      pix_en = 1'b0;
      {mv_left, mv_right, mv_up, mv_down} = 4'b0000;
      drv_vld = 1'b0;
   endtask

   task automatic checkv(input string nm, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
      end
   endtask

   task automatic cmp_out(input string nm, input exp_t e, input int act, input int idx,
                          input int x, input int y, input int cidx, input int hit);
      nvec++;
      if (act != e.act || idx != e.idx || x != e.x || y != e.y || cidx != e.cidx || hit != e.hit) begin
         nerr++;
         $display("FAIL %s t=%0t got act=%0d idx=%0d x=%0d y=%0d cidx=%0d hit=%0d expected act=%0d idx=%0d x=%0d y=%0d cidx=%0d hit=%0d",
                  nm, $time, act, idx, x, y, cidx, hit, e.act, e.idx, e.x, e.y, e.cidx, e.hit);
      end
   endtask

   task automatic check_all_zero(input string tag);
      checkv({tag, "_a_act"},  int'(a_in_active),  0);
      checkv({tag, "_a_idx"},  int'(a_tile_idx),   0);
      checkv({tag, "_a_x"},    int'(a_tile_x),     0);
      checkv({tag, "_a_y"},    int'(a_tile_y),     0);
      checkv({tag, "_a_cidx"}, int'(a_cursor_idx), 0);
      checkv({tag, "_a_hit"},  int'(a_cursor_hit), 0);
      checkv({tag, "_b_act"},  int'(b_in_active),  0);
      checkv({tag, "_b_idx"},  int'(b_tile_idx),   0);
      checkv({tag, "_b_x"},    int'(b_tile_x),     0);
      checkv({tag, "_b_y"},    int'(b_tile_y),     0);
      checkv({tag, "_b_cidx"}, int'(b_cursor_idx), 0);
      checkv({tag, "_b_hit"},  int'(b_cursor_hit), 0);
   endtask

   // Monitor: every driven cycle presents one output sample after the following rising edge.
   initial begin
      bit   s;
      exp_t e0, e1;
      forever begin
         @(posedge clk);
         s = drv_vld;
         @(negedge clk);
         if (s) begin
            if (q0.size() == 0 || q1.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL scoreboard_underflow t=%0t got q0=%0d q1=%0d expected nonempty", $time, q0.size(), q1.size());
            end else begin
               e0 = q0.pop_front();
               e1 = q1.pop_front();
               cmp_out("dutA", e0, int'(a_in_active), int'(a_tile_idx), int'(a_tile_x), int'(a_tile_y),
                       int'(a_cursor_idx), int'(a_cursor_hit));
               cmp_out("dutB", e1, int'(b_in_active), int'(b_tile_idx), int'(b_tile_x), int'(b_tile_y),
                       int'(b_cursor_idx), int'(b_cursor_hit));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      nerr++;
      $display("FAIL watchdog t=%0t got timeout expected completion", $time);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [3:0] rmv(input int mode);
      logic [3:0] m = '0;
      if (mode == 2) begin
         for (int i = 0; i < 4; i++) m[i] = ($urandom_range(7) == 0);
      end
      return m;
   endfunction

   task automatic cursor_setup();
      drive(0, 0, 0, 4'b1000);
      @(posedge clk); #1;
      checkv("cur_left_a", int'(a_cursor_idx), 1);
      checkv("cur_left_b", int'(b_cursor_idx), 3);
      drive(0, 0, 0, 4'b0010);
      @(posedge clk); #1;
      checkv("cur_up_a", int'(a_cursor_idx), 3);
      checkv("cur_up_b", int'(b_cursor_idx), 11);
      drive(0, 0, 0, 4'b1100);
      @(posedge clk); #1;
      checkv("cur_lr_a", int'(a_cursor_idx), 3);
      checkv("cur_lr_b", int'(b_cursor_idx), 11);
   endtask

   // Known grid points with the cursor at a=3 (col1,row1) and b=11 (col3,row2).
   task automatic spot(input int h, input int v);
      if ((v == 10 && (h == 319 || h == 320 || h == 700)) || (v == 239 && h == 0) ||
          (v == 240 && (h == 0 || h == 320)) || (v == 479 && h == 639) ||
          (v == 330 && h == 480) || (v == 500 && h == 0) || (v == 0 && h == 0)) begin
         @(posedge clk); #1;
         if (v == 0) begin
            checkv("f0_a_act", int'(a_in_active), 1);
            checkv("f0_a_idx", int'(a_tile_idx), 0);
         end
         if (v == 10 && h == 319) begin
            checkv("v10h319_a_idx", int'(a_tile_idx), 0);
            checkv("v10h319_a_x", int'(a_tile_x), 319);
         end
         if (v == 10 && h == 320) begin
            checkv("v10h320_a_idx", int'(a_tile_idx), 1);
            checkv("v10h320_a_x", int'(a_tile_x), 0);
            checkv("v10h320_a_hit", int'(a_cursor_hit), 0);
         end
         if (v == 10 && h == 700) begin
            checkv("hblank_a_act", int'(a_in_active), 0);
            checkv("hblank_a_idx", int'(a_tile_idx), 0);
            checkv("hblank_a_hit", int'(a_cursor_hit), 0);
         end
         if (v == 239) begin
            checkv("v239_a_idx", int'(a_tile_idx), 0);
            checkv("v239_a_y", int'(a_tile_y), 239);
         end
         if (v == 240 && h == 0) begin
            checkv("v240_a_idx", int'(a_tile_idx), 2);
            checkv("v240_a_y", int'(a_tile_y), 0);
         end
         if (v == 240 && h == 320) checkv("v240h320_a_hit", int'(a_cursor_hit), 1);
         if (v == 479) begin
            checkv("v479h639_a_idx", int'(a_tile_idx), 3);
            checkv("v479h639_b_idx", int'(b_tile_idx), 11);
         end
         if (v == 330) begin
            checkv("g43_b_idx", int'(b_tile_idx), 11);
            checkv("g43_b_x", int'(b_tile_x), 0);
            checkv("g43_b_y", int'(b_tile_y), 10);
            checkv("g43_b_hit", int'(b_cursor_hit), 1);
         end
         if (v == 500) begin
            checkv("vblank_a_act", int'(a_in_active), 0);
            checkv("vblank_a_idx", int'(a_tile_idx), 0);
         end
      end
   endtask

   task automatic mid_reset(input int h, input int v);
      idle();
      idle();
      reset = 1'b1;
      #1;
      check_all_zero("midrst");
      model_reset();
      idle();
      idle();
      reset = 1'b0;
      drive(0, h, v, 4'b1000);
      drive(0, h, v, 4'b0010);
   endtask

   // mode 0: plain frame with spot checks; 1: reset at (400,300); 2: random moves and hcnt jumps.
   task automatic scan_frame(input int mode);
      int h;
      bit full;
      for (int v = 0; v < VT; v++) begin
         full = (v == 10 || v == 239 || v == 240 || v == 330 || v == 479 || v == 500 ||
                 (mode == 1 && v == 300));
         if (!full) begin
            drive(1, 0, v, rmv(mode));
            if (mode == 0) spot(0, v);
            if ($urandom_range(3) == 0) drive(0, 0, v, rmv(mode));
         end else begin
            h = 0;
            while (h < HT) begin
               if (mode == 1 && v == 300 && h == 400) mid_reset(h, v);
               drive(1, h, v, rmv(mode));
               if (mode == 0) spot(h, v);
               if ($urandom_range(3) == 0) drive(0, h, v, rmv(mode));
               if (mode == 2 && $urandom_range(15) == 0) h += int'($urandom_range(5, 2));
               else                                      h++;
            end
         end
      end
   endtask

   initial begin
      model_reset();
      #1;
      reset = 1'b1;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cursor_setup();
      scan_frame(0);
      scan_frame(1);
      scan_frame(0);
      scan_frame(2);
      idle();
      idle();
      checkv("drain_q0", q0.size(), 0);
      checkv("drain_q1", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/vga_tile_tracker.md
Name: vga_tile_tracker

Overview:
- Parametrised successor to the fixed four-quadrant screen selector in the VGA display path.
- Divides the active area into a COLS x ROWS grid of equal tiles and tracks, without dividers, the current tile index and the pixel offset inside that tile.
- Also holds a user-movable cursor tile and flags pixels that fall in that tile.
- Sits between the VGA timing counters and the per-tile pixel generators / colour mux.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- COLS, 2, tile columns; H_ACTIVE must be divisible by COLS.
- ROWS, 2, tile rows; V_ACTIVE must be divisible by ROWS.
- CNT_W, 10, width of hcnt/vcnt.
- Derived localparams: TILE_W=H_ACTIVE/COLS, TILE_H=V_ACTIVE/ROWS, IDX_W=max(1,$clog2(COLS*ROWS)), X_W=max(1,$clog2(TILE_W)), Y_W=max(1,$clog2(TILE_H)).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel tick; the hcnt/vcnt sample is valid on this cycle
- hcnt  in  CNT_W  horizontal counter, incrementing by 1 per pix_en, 0 at line start
- vcnt  in  CNT_W  vertical counter, constant during a line, 0 on the first line
- mv_left, mv_right, mv_up, mv_down  in  1 each  single-cycle cursor move pulses
- in_active  out  1  registered: sample lies in the visible area
- tile_idx  out  IDX_W  registered: row*COLS+col of the sample
- tile_x  out  X_W  registered: x offset inside the tile
- tile_y  out  Y_W  registered: y offset inside the tile
- cursor_idx  out  IDX_W  current cursor tile
- cursor_hit  out  1  registered: in_active && tile_idx==cursor_idx

Behaviour:
- Reset (async assert, sync deassert handled upstream): all state and outputs go to 0; cursor at tile 0 (col 0, row 0).
- All updates occur only on cycles with pix_en=1, except cursor moves. Between ticks, outputs hold.
- Latency: outputs reflect the hcnt/vcnt sample of a pix_en cycle on the next rising edge (1 clk).
- Horizontal tracker (xoff, col):
  - On pix_en with hcnt==0: xoff=0, col=0.
  - Otherwise: xoff increments. When xoff==TILE_W-1, xoff wraps to 0 and col increments.
  - col saturates at COLS-1 once hcnt>=H_ACTIVE.
- Vertical tracker (yoff, row): advances only on pix_en with hcnt==0.
  - If vcnt==0: yoff=0, row=0.
  - Else: yoff increments. When yoff==TILE_H-1, yoff wraps to 0 and row increments; row saturates at ROWS-1.
- Active gating:
  - in_active = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE).
  - When inactive, tile_idx, tile_x, tile_y and cursor_hit output 0, but the internal trackers keep their state.
- tile_idx arithmetic: row*COLS+col at IDX_W width; never exceeds COLS*ROWS-1.
- Cursor (cur_col, cur_row):
  - mv_right: col+1, wrapping COLS-1 -> 0. mv_left: col-1, wrapping 0 -> COLS-1.
  - mv_down: row+1, wrapping ROWS-1 -> 0. mv_up: row-1, wrapping 0 -> ROWS-1.
  - Simultaneous left+right: no column change. Simultaneous up+down: no row change. Horizontal and vertical moves in the same cycle both apply.
  - A move takes effect on the next edge regardless of pix_en.
  - cursor_hit uses the updated cursor value from that edge onward.
  - cursor_idx = cur_row*COLS+cur_col, registered.
- Resynchronisation: a non-contiguous hcnt jump is not corrected until the next hcnt==0; vertical equivalently at the next vcnt==0.
- Reset mid-frame: everything returns to 0; correct tracking resumes at the next hcnt==0 / vcnt==0.

Decomposition:
- Package vga_pkg: default H_ACTIVE/V_ACTIVE, CNT_W, and a function clog2_min1.
- One natural sub-module, tile_axis_counter, parametrised by TILE and N.
  - Provides the offset/index counter with restart, wrap and saturate.
  - Instantiated twice: horizontal with step=pix_en, vertical with step=pix_en&&hcnt==0.
- The cursor wrap counter stays inline.

Test Plan:
- Default 2x2 grid, scan of line vcnt=10: hcnt=319 -> tile_idx=0, tile_x=319; hcnt=320 -> tile_idx=1, tile_x=0, one clk after pix_en.
- Line vcnt=239 vs vcnt=240 at hcnt=0: tile_idx 0 vs 2, with tile_y=239 then 0. Line vcnt=479 at hcnt=639: tile_idx=3.
- Blanking: hcnt=640..799 or vcnt=480..524 -> in_active=0, tile_idx=0, cursor_hit=0; the next frame starts at tile 0.
- COLS=4, ROWS=3 (TILE 160x160): hcnt=480, vcnt=330 -> tile_idx=11, tile_x=0, tile_y=10.
- Cursor in 2x2: mv_left from reset -> cursor_idx=1; mv_up -> 3; mv_left+mv_right together -> unchanged 3. Scan shows cursor_hit=1 only for hcnt>=320, vcnt>=240.
- Assert reset at hcnt=400, vcnt=300: all outputs 0 immediately. After release, the next full frame reproduces the same outputs as a frame with no reset.
